board_input_ctrl: RTL and testbench



---
 rtl/board_input_ctrl.sv | 150 +++++++++++++++
 tb/tb_board_input_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/board_input_ctrl.sv
// Front-panel input conditioner: sync, debounce, step/run advance strobe.
// Counterpart of the seven-segment output path.

// Two-flop synchronizer plus debounce for a W-bit channel.
// A change of the synced value while a mismatch is pending restarts the count.
module board_input_db #(
   parameter int W               = 1,
   parameter int DEBOUNCE_CYCLES = 200000
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] raw,
   output logic [W-1:0] stable
);
   localparam logic [19:0] CMAX = 20'(DEBOUNCE_CYCLES - 1);

   logic [W-1:0] s1;
   logic [W-1:0] s2;
   logic [W-1:0] s3;
   logic [19:0]  cnt;

   // synchronize, then accept a level only after CMAX+1 matching cycles
   always_ff @(posedge clock) begin
      if (reset) begin
         s1     <= '0;
         s2     <= '0;
         s3     <= '0;
         cnt    <= '0;
         stable <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         s3 <= s2;
         if (s2 == stable) begin
            cnt <= '0;
         end else if (s2 != s3) begin
            cnt <= 20'd1;
         end else if (cnt == CMAX) begin
            stable <= s2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 20'd1;
         end
      end
   end
endmodule

module board_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 200000,
   parameter int RUN_DIV         = 50000000,
   parameter int CNT_W           = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             btn_step,
   input  logic             btn_mode,
   input  logic [5:0]       sw_sel,
   output logic             advance,
   output logic             run_mode,
   output logic [5:0]       sel_out,
   output logic [CNT_W-1:0] adv_count
);
   localparam logic [25:0] DMAX = 26'(RUN_DIV - 1);

   typedef enum logic {
      STEP = 1'b0,
      RUN  = 1'b1
   } mode_t;

   mode_t       state;
   logic        step_st;
   logic        mode_st;
   logic        step_q;
   logic        mode_q;
   logic        step_rise;
   logic        mode_rise;
   logic [25:0] div;

   board_input_db #(
      .W               (1),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_step (
      .clock  (clock),
      .reset  (reset),
      .raw    (btn_step),
      .stable (step_st)
   );

   board_input_db #(
      .W               (1),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_mode (
      .clock  (clock),
      .reset  (reset),
      .raw    (btn_mode),
      .stable (mode_st)
   );

   board_input_db #(
      .W               (6),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_sel (
      .clock  (clock),
      .reset  (reset),
      .raw    (sw_sel),
      .stable (sel_out)
   );

   assign step_rise = step_st & ~step_q;
   assign mode_rise = mode_st & ~mode_q;

   // mode FSM and advance generation; a mode toggle swallows any step event
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= STEP;
         run_mode <= 1'b0;
         step_q   <= 1'b0;
         mode_q   <= 1'b0;
         div      <= '0;
         advance  <= 1'b0;
      end else begin
         step_q  <= step_st;
         mode_q  <= mode_st;
         advance <= 1'b0;
         if (mode_rise) begin
            state    <= (state == STEP) ? RUN : STEP;
            run_mode <= (state == STEP);
            div      <= '0;
         end else if (state == RUN) begin
            if (div == DMAX) begin
               div     <= '0;
               advance <= 1'b1;
            end else begin
               div <= div + 26'd1;
            end
         end else begin
            advance <= step_rise;
         end
      end
   end

   // count issued strobes, wrapping silently
   always_ff @(posedge clock) begin
      if (reset) begin
         adv_count <= '0;
      end else if (advance) begin
         adv_count <= adv_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_board_input_ctrl.sv
// Bench for board_input_ctrl: directed stimulus, advance strobes
// checked by a scoreboard monitor against expected cycle and count.
module tb_board_input_ctrl;
   localparam int DB = 4;
   localparam int RD = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        btn_step = 1'b0;
   logic        btn_mode = 1'b0;
   logic [5:0]  sw_sel = 6'd0;
   logic        advance;
   logic        run_mode;
   logic [5:0]  sel_out;
   logic [15:0] adv_count;
   logic        advance_w;
   logic        run_mode_w;
   logic [5:0]  sel_out_w;
   logic [2:0]  adv_count_w;

   board_input_ctrl #(
      .DEBOUNCE_CYCLES (DB),
      .RUN_DIV         (RD),
      .CNT_W           (16)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .btn_step  (btn_step),
      .btn_mode  (btn_mode),
      .sw_sel    (sw_sel),
      .advance   (advance),
      .run_mode  (run_mode),
      .sel_out   (sel_out),
      .adv_count (adv_count)
   );

   // narrow counter copy so the wrap is reached in a short run
   board_input_ctrl #(
      .DEBOUNCE_CYCLES (DB),
      .RUN_DIV         (RD),
      .CNT_W           (3)
   ) dut_w (
      .clock     (clock),
      .reset     (reset),
      .btn_step  (btn_step),
      .btn_mode  (btn_mode),
      .sw_sel    (sw_sel),
      .advance   (advance_w),
      .run_mode  (run_mode_w),
      .sel_out   (sel_out_w),
      .adv_count (adv_count_w)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int cnt;
   } exp_t;

   exp_t sb[$];
   exp_t me;
   int   n_chk = 0;
   int   n_fail = 0;
   int   exp_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic push(input int c);
      sb.push_back('{cyc: c, cnt: exp_cnt});
      exp_cnt++;
   endtask

   // monitor: every strobe must match the oldest expected entry
   always @(negedge clock) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         me = sb.pop_front();
         chk("advance_missed", cyc, me.cyc);
      end
      if (advance) begin
         if (sb.size() == 0) begin
            chk("advance_unexpected", cyc, -1);
         end else begin
            me = sb.pop_front();
            chk("advance_cycle", cyc, me.cyc);
            chk("adv_count", int'(adv_count), me.cnt);
            chk("adv_count_wrap", int'(adv_count_w), me.cnt % 8);
            chk("advance_twin", int'(advance_w), 1);
         end
      end
   end

   int t;
   int m;
   int r;

   initial begin
      btn_step = 1'b1;
      sw_sel   = 6'h3F;
      reset    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("rst_advance", int'(advance), 0);
         chk("rst_run_mode", int'(run_mode), 0);
         chk("rst_sel_out", int'(sel_out), 0);
         chk("rst_adv_count", int'(adv_count), 0);
      end
      reset = 1'b0;
      push(cyc + 7);
      tick(1);
      chk("adv_after_release", int'(advance), 0);
      tick(12);
      chk("count_after_reset_press", int'(adv_count), 1);
      chk("sel_after_reset", int'(sel_out), 6'h3F);
      chk("mode_after_reset", int'(run_mode), 0);

      btn_step = 1'b0;
      tick(10);
      btn_step = 1'b1; tick(1);
      btn_step = 1'b0; tick(1);
      btn_step = 1'b1; tick(1);
      btn_step = 1'b0; tick(1);
      btn_step = 1'b1;
      push(cyc + 7);
      tick(20);
      btn_step = 1'b0;
      tick(10);
      btn_step = 1'b1;
      push(cyc + 7);
      tick(12);
      btn_step = 1'b0;
      tick(10);
      chk("count_after_steps", int'(adv_count), 3);

      sw_sel = 6'd0;
      tick(10);
      chk("sel_zero", int'(sel_out), 0);
      sw_sel = 6'd5;
      tick(2);
      sw_sel = 6'd7;
      tick(2);
      sw_sel = 6'd5;
      t = cyc;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("sel_never_7", int'(sel_out == 6'd7), 0);
         if (cyc == t + 5) chk("sel_before_settle", int'(sel_out), 0);
         if (cyc == t + 6) chk("sel_settled", int'(sel_out), 5);
      end

      btn_mode = 1'b1;
      m = cyc;
      for (int k = 0; k < 10; k++) push(m + 15 + RD * k);
      tick(12);
      btn_mode = 1'b0;
      tick(10);
      btn_step = 1'b1;
      tick(12);
      btn_step = 1'b0;
      chk("run_mode_on", int'(run_mode), 1);
      tick(m + 88 - cyc);
      chk("count_after_run", int'(adv_count), 13);

      btn_step = 1'b1;
      btn_mode = 1'b1;
      tick(7);
      chk("run_mode_toggled_off", int'(run_mode), 0);
      tick(7);
      btn_step = 1'b0;
      btn_mode = 1'b0;
      tick(12);
      chk("count_after_simul", int'(adv_count), 13);
      chk("mode_after_simul", int'(run_mode), 0);

      btn_mode = 1'b1;
      r = cyc;
      push(r + 15);
      push(r + 23);
      tick(12);
      btn_mode = 1'b0;
      tick(r + 26 - cyc);
      chk("run_before_reset", int'(run_mode), 1);
      reset = 1'b1;
      exp_cnt = 0;
      tick(1);
      chk("midrun_rst_mode", int'(run_mode), 0);
      chk("midrun_rst_count", int'(adv_count), 0);
      chk("midrun_rst_adv", int'(advance), 0);
      tick(1);
      reset = 1'b0;
      tick(40);
      chk("post_rst_mode", int'(run_mode), 0);
      chk("post_rst_count", int'(adv_count), 0);
      chk("post_rst_sel", int'(sel_out), 5);
      tick(2);
      chk("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
